// File: rtl/ibex_rf_write_sequencer_if.sv
// Write-port bundle between the writeback requesters, the sequencer and the register file.
interface ibex_rf_write_sequencer_if #(
  parameter int unsigned NumReq    = 2,
  parameter int unsigned DataWidth = 32
);
  logic [NumReq-1:0]           req_valid_i;
  logic [NumReq-1:0]           req_ready_o;
  logic [NumReq*5-1:0]         req_addr_i;
  logic [NumReq*DataWidth-1:0] req_wdata_i;
  logic                        clear_req_i;
  logic [4:0]                  waddr_a_o;
  logic [DataWidth-1:0]        wdata_a_o;
  logic                        we_a_o;
  logic                        init_done_o;

  modport slave (
    input  req_valid_i, req_addr_i, req_wdata_i, clear_req_i,
    output req_ready_o, waddr_a_o, wdata_a_o, we_a_o, init_done_o
  );

  modport master (
    output req_valid_i, req_addr_i, req_wdata_i, clear_req_i,
    input  req_ready_o, waddr_a_o, wdata_a_o, we_a_o, init_done_o
  );
endinterface

// File: rtl/ibex_rf_write_sequencer.sv
// Clears the unreset latch register file after reset, then round-robin arbitrates
// its single write port between NumReq requesters.
module ibex_rf_write_sequencer #(
  parameter bit                   RV32E        = 1'b0,
  parameter int unsigned          DataWidth    = 32,
  parameter int unsigned          NumReq       = 2,
  parameter bit                   ClearOnReset = 1'b1,
  parameter logic [DataWidth-1:0] WordZeroVal  = '0
) (
  input logic                      clk_i,
  input logic                      rst_ni,
  ibex_rf_write_sequencer_if.slave bus_io
);

  localparam int unsigned    RrW      = $clog2(NumReq);
  localparam logic [4:0]     LastAddr = RV32E ? 5'd15 : 5'd31;
  localparam logic [RrW-1:0] LastReq  = RrW'(NumReq - 1);

  typedef enum logic [0:0] {StClear, StArb} state_e;

  state_e               state_q;
  logic [4:0]           cnt_q;
  logic [RrW-1:0]       rr_q;
  logic                 we_q;
  logic [4:0]           waddr_q;
  logic [DataWidth-1:0] wdata_q;
  logic                 init_done_q;

  logic                 gnt_valid;
  logic [RrW-1:0]       gnt_idx;
  logic [4:0]           sel_addr;
  logic [4:0]           wr_addr;
  logic [DataWidth-1:0] sel_data;
  logic                 hs;
  logic [NumReq-1:0]    ready;

  // Two passes: requesters at or above the pointer first, then the wrapped-around ones.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      if (!gnt_valid && bus_io.req_valid_i[k] && (RrW'(k) >= rr_q)) begin
        gnt_valid = 1'b1;
        gnt_idx   = RrW'(k);
      end
    end
    for (int unsigned k = 0; k < NumReq; k++) begin
      if (!gnt_valid && bus_io.req_valid_i[k] && (RrW'(k) < rr_q)) begin
        gnt_valid = 1'b1;
        gnt_idx   = RrW'(k);
      end
    end
  end

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      if (RrW'(k) == gnt_idx) begin
        sel_addr = bus_io.req_addr_i[5*k +: 5];
        sel_data = bus_io.req_wdata_i[DataWidth*k +: DataWidth];
      end
    end
  end

  assign wr_addr = RV32E ? {1'b0, sel_addr[3:0]} : sel_addr;

  // A pending clear suppresses any grant; ready is also held low while in reset.
  always_comb begin
    hs    = rst_ni && (state_q == StArb) && !bus_io.clear_req_i && gnt_valid;
    ready = '0;
    if (hs) begin
      ready[gnt_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ClearOnReset ? StClear : StArb;
      cnt_q       <= 5'd1;
      rr_q        <= '0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= WordZeroVal;
      init_done_q <= !ClearOnReset;
    end else begin
      unique case (state_q)
        StClear: begin
          we_q    <= 1'b1;
          waddr_q <= cnt_q;
          wdata_q <= WordZeroVal;
          if (cnt_q == LastAddr) begin
            state_q     <= StArb;
            cnt_q       <= 5'd1;
            init_done_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 5'd1;
          end
        end
        StArb: begin
          if (bus_io.clear_req_i) begin
            state_q     <= StClear;
            cnt_q       <= 5'd1;
            init_done_q <= 1'b0;
            we_q        <= 1'b0;
          end else if (hs) begin
            rr_q <= (gnt_idx == LastReq) ? '0 : gnt_idx + 1'b1;
            // Writes to word 0 are accepted but dropped.
            if (wr_addr != 5'd0) begin
              we_q    <= 1'b1;
              waddr_q <= wr_addr;
              wdata_q <= sel_data;
            end else begin
              we_q <= 1'b0;
            end
          end else begin
            we_q <= 1'b0;
          end
        end
        default: state_q <= StArb;
      endcase
    end
  end

  assign bus_io.req_ready_o = ready;
  assign bus_io.we_a_o      = we_q;
  assign bus_io.waddr_a_o   = waddr_q;
  assign bus_io.wdata_a_o   = wdata_q;
  assign bus_io.init_done_o = init_done_q;

endmodule

// File: tb/tb_ibex_rf_write_sequencer.sv
// Directed bench: RV32I/2-requester instance with clear-on-reset, plus RV32E/3-requester
// instance without clear.
module tb_ibex_rf_write_sequencer;

  localparam logic [31:0] Zv1 = 32'hC1EA_0000;
  localparam logic [31:0] Zv2 = 32'h5EED_0002;

  logic clk    = 1'b0;
  logic rst_n  = 1'b1;
  logic rst2_n = 1'b1;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  ibex_rf_write_sequencer_if #(.NumReq(2), .DataWidth(32)) bus1 ();
  ibex_rf_write_sequencer_if #(.NumReq(3), .DataWidth(32)) bus2 ();

  ibex_rf_write_sequencer #(
    .RV32E       (1'b0),
    .DataWidth   (32),
    .NumReq      (2),
    .ClearOnReset(1'b1),
    .WordZeroVal (Zv1)
  ) u_dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus_io(bus1)
  );

  ibex_rf_write_sequencer #(
    .RV32E       (1'b1),
    .DataWidth   (32),
    .NumReq      (3),
    .ClearOnReset(1'b0),
    .WordZeroVal (Zv2)
  ) u_dut_e (
    .clk_i (clk),
    .rst_ni(rst2_n),
    .bus_io(bus2)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    bus1.req_valid_i = 2'b11;
    bus1.req_addr_i  = {5'd6, 5'd5};
    bus1.req_wdata_i = {32'h0000_5A5A, 32'hA5A5_0000};
    bus1.clear_req_i = 1'b0;
    bus2.req_valid_i = 3'b111;
    bus2.req_addr_i  = {5'h1F, 5'h12, 5'h01};
    bus2.req_wdata_i = {32'h1000_0002, 32'h1000_0001, 32'h1000_0000};
    bus2.clear_req_i = 1'b0;
    #1 rst_n = 1'b0;
    rst2_n = 1'b0;
    #1;
    chk("rst_we", 32'(bus1.we_a_o), 32'd0);
    chk("rst_waddr", 32'(bus1.waddr_a_o), 32'd0);
    chk("rst_wdata", bus1.wdata_a_o, Zv1);
    chk("rst_init_done", 32'(bus1.init_done_o), 32'd0);
    chk("rst_ready", 32'(bus1.req_ready_o), 32'd0);
    chk("rst_e_init_done", 32'(bus2.init_done_o), 32'd1);
    chk("rst_e_ready", 32'(bus2.req_ready_o), 32'd0);
    chk("rst_e_wdata", bus2.wdata_a_o, Zv2);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_we", 32'(bus1.we_a_o), 32'd0);
    chk("rst_hold_ready", 32'(bus1.req_ready_o), 32'd0);
    bus1.req_valid_i = 2'b00;
    bus2.req_valid_i = 3'b000;
    @(negedge clk);
    rst_n  = 1'b1;
    rst2_n = 1'b1;
  endtask

  task automatic test_clear();
    for (int a = 1; a <= 31; a++) begin
      @(posedge clk);
      #1;
      chk($sformatf("clear_we_%0d", a), 32'(bus1.we_a_o), 32'd1);
      chk($sformatf("clear_addr_%0d", a), 32'(bus1.waddr_a_o), 32'(a));
      chk($sformatf("clear_data_%0d", a), bus1.wdata_a_o, Zv1);
      chk($sformatf("clear_init_%0d", a), 32'(bus1.init_done_o), 32'(a == 31));
    end
  endtask

  // Entered in the cycle after the addr-31 clear write; pointer is 0.
  task automatic test_round_robin();
    logic [1:0] exp_rdy;
    int g;
    bus1.req_valid_i = 2'b11;
    bus1.req_addr_i  = {5'd6, 5'd5};
    bus1.req_wdata_i = {32'h0000_5A5A, 32'hA5A5_0000};
    for (int i = 0; i < 6; i++) begin
      g = i % 2;
      exp_rdy = 2'b01 << g;
      #1;
      chk($sformatf("rr_ready_%0d", i), 32'(bus1.req_ready_o), 32'(exp_rdy));
      @(posedge clk);
      #1;
      chk($sformatf("rr_we_%0d", i), 32'(bus1.we_a_o), 32'd1);
      chk($sformatf("rr_addr_%0d", i), 32'(bus1.waddr_a_o), (g == 1) ? 32'd6 : 32'd5);
      chk($sformatf("rr_data_%0d", i), bus1.wdata_a_o,
          (g == 1) ? 32'h0000_5A5A : 32'hA5A5_0000);
    end
    bus1.req_valid_i = 2'b00;
    @(posedge clk);
    #1;
    chk("rr_idle_we", 32'(bus1.we_a_o), 32'd0);
    chk("rr_idle_addr", 32'(bus1.waddr_a_o), 32'd6);
    chk("rr_idle_data", bus1.wdata_a_o, 32'h0000_5A5A);
  endtask

  task automatic test_addr_zero();
    bus1.req_addr_i  = {5'd0, 5'd5};
    bus1.req_wdata_i = {32'hDEAD_BEEF, 32'hA5A5_0000};
    bus1.req_valid_i = 2'b10;
    #1;
    chk("az_ready", 32'(bus1.req_ready_o), 32'b10);
    @(posedge clk);
    #1;
    bus1.req_valid_i = 2'b00;
    chk("az_we", 32'(bus1.we_a_o), 32'd0);
    chk("az_addr_hold", 32'(bus1.waddr_a_o), 32'd6);
    chk("az_data_hold", bus1.wdata_a_o, 32'h0000_5A5A);
    #1;
    chk("az_ready_drop", 32'(bus1.req_ready_o), 32'd0);
  endtask

  task automatic test_clear_req();
    bus1.req_addr_i  = {5'd0, 5'd9};
    bus1.req_wdata_i = {32'h0, 32'h1234_5678};
    bus1.req_valid_i = 2'b01;
    bus1.clear_req_i = 1'b1;
    #1;
    chk("cr_ready_blocked", 32'(bus1.req_ready_o), 32'd0);
    chk("cr_init_before", 32'(bus1.init_done_o), 32'd1);
    @(posedge clk);
    #1;
    bus1.clear_req_i = 1'b0;
    chk("cr_init_fall", 32'(bus1.init_done_o), 32'd0);
    chk("cr_we_gap", 32'(bus1.we_a_o), 32'd0);
    #1;
    chk("cr_ready_clear", 32'(bus1.req_ready_o), 32'd0);
    for (int a = 1; a <= 31; a++) begin
      @(posedge clk);
      #1;
      chk($sformatf("cr_we_%0d", a), 32'(bus1.we_a_o), 32'd1);
      chk($sformatf("cr_addr_%0d", a), 32'(bus1.waddr_a_o), 32'(a));
      chk($sformatf("cr_init_%0d", a), 32'(bus1.init_done_o), 32'(a == 31));
      #1;
      chk($sformatf("cr_ready_%0d", a), 32'(bus1.req_ready_o), (a == 31) ? 32'd1 : 32'd0);
    end
    @(posedge clk);
    #1;
    bus1.req_valid_i = 2'b00;
    chk("cr_post_we", 32'(bus1.we_a_o), 32'd1);
    chk("cr_post_addr", 32'(bus1.waddr_a_o), 32'd9);
    chk("cr_post_data", bus1.wdata_a_o, 32'h1234_5678);
  endtask

  task automatic test_reset_mid_clear();
    bus1.clear_req_i = 1'b1;
    @(posedge clk);
    #1;
    bus1.clear_req_i = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("mid_addr10", 32'(bus1.waddr_a_o), 32'd10);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we", 32'(bus1.we_a_o), 32'd0);
    chk("mid_rst_addr", 32'(bus1.waddr_a_o), 32'd0);
    chk("mid_rst_data", bus1.wdata_a_o, Zv1);
    chk("mid_rst_init", 32'(bus1.init_done_o), 32'd0);
    @(posedge clk);
    #1;
    chk("mid_rst_hold_we", 32'(bus1.we_a_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int a = 1; a <= 3; a++) begin
      @(posedge clk);
      #1;
      chk($sformatf("mid_restart_we_%0d", a), 32'(bus1.we_a_o), 32'd1);
      chk($sformatf("mid_restart_addr_%0d", a), 32'(bus1.waddr_a_o), 32'(a));
    end
  endtask

  task automatic test_cfg_rv32e();
    logic [2:0] exp_rdy;
    logic [4:0] exp_addr [3];
    int g;
    exp_addr[0] = 5'd1;
    exp_addr[1] = 5'd2;
    exp_addr[2] = 5'd15;
    chk("e_init_done", 32'(bus2.init_done_o), 32'd1);
    chk("e_we_idle", 32'(bus2.we_a_o), 32'd0);
    bus2.req_addr_i  = {5'h13, 5'h12, 5'h01};
    bus2.req_wdata_i = {32'hCAFE_0002, 32'h1000_0001, 32'h1000_0000};
    bus2.req_valid_i = 3'b100;
    #1;
    chk("e_trunc_ready", 32'(bus2.req_ready_o), 32'b100);
    @(posedge clk);
    #1;
    chk("e_trunc_we", 32'(bus2.we_a_o), 32'd1);
    chk("e_trunc_addr", 32'(bus2.waddr_a_o), 32'h03);
    chk("e_trunc_data", bus2.wdata_a_o, 32'hCAFE_0002);
    bus2.req_addr_i  = {5'h1F, 5'h12, 5'h01};
    bus2.req_wdata_i = {32'h1000_0002, 32'h1000_0001, 32'h1000_0000};
    bus2.req_valid_i = 3'b111;
    for (int i = 0; i < 6; i++) begin
      g = i % 3;
      exp_rdy = 3'b001 << g;
      #1;
      chk($sformatf("e_rr_ready_%0d", i), 32'(bus2.req_ready_o), 32'(exp_rdy));
      @(posedge clk);
      #1;
      chk($sformatf("e_rr_addr_%0d", i), 32'(bus2.waddr_a_o), 32'(exp_addr[g]));
      chk($sformatf("e_rr_data_%0d", i), bus2.wdata_a_o, 32'h1000_0000 + 32'(g));
    end
    bus2.req_valid_i = 3'b000;
  endtask

  initial begin
    test_reset();
    test_clear();
    test_round_robin();
    test_addr_zero();
    test_clear_req();
    test_cfg_rv32e();
    test_reset_mid_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
